// File: rtl/clip_record_controller.sv
// Record/playback sequencer for NUM_CLIPS audio clips, one memory bank per clip.
// Addresses advance per serializer/deserializer sample handshake; per-clip lengths gate playback.
module clip_record_controller #(
  parameter int NUM_CLIPS  = 2,
  parameter int ADDR_WIDTH = 17,
  parameter int CLIP_DEPTH = 131072,
  localparam int CLIP_BITS = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1,
  localparam int LEN_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  play_command_i,
  input  logic                  record_command_i,
  input  logic                  stop_command_i,
  input  logic                  loop_enable_i,
  input  logic [CLIP_BITS-1:0]  clip_select_i,
  input  logic                  serializer_done_i,
  input  logic                  deserializer_done_i,
  output logic                  serializer_enable_o,
  output logic                  deserializer_enable_o,
  output logic [ADDR_WIDTH-1:0] memory_addr_o,
  output logic                  memory_rw_o,
  output logic                  memory_strobe_o,
  output logic [CLIP_BITS-1:0]  memory_bank_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NUM_CLIPS-1:0]  clip_valid_o
);

  typedef enum logic [1:0] {IDLE, PLAY, RECORD} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLIP_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CLIP_BITS-1:0]  bank_q, bank_d;
  logic                  strobe_q, strobe_d;
  logic                  done_q, done_d;
  logic                  stopPending_q, stopPending_d;
  logic [LEN_WIDTH-1:0]  clipLen_q [NUM_CLIPS];
  logic [LEN_WIDTH-1:0]  clipLen_d [NUM_CLIPS];

  logic                  selValid;
  logic [LEN_WIDTH-1:0]  selLen;
  logic [LEN_WIDTH-1:0]  bankLen;
  logic [LEN_WIDTH-1:0]  recordedLen;

  assign selValid    = 32'(clip_select_i) < 32'(NUM_CLIPS);
  assign selLen      = selValid ? clipLen_q[clip_select_i] : '0;
  assign bankLen     = clipLen_q[bank_q];
  assign recordedLen = LEN_WIDTH'(addr_q) + LEN_WIDTH'(strobe_q);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      bank_q        <= '0;
      strobe_q      <= 1'b0;
      done_q        <= 1'b0;
      stopPending_q <= 1'b0;
      clipLen_q     <= '{default: '0};
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      bank_q        <= bank_d;
      strobe_q      <= strobe_d;
      done_q        <= done_d;
      stopPending_q <= stopPending_d;
      clipLen_q     <= clipLen_d;
    end
  end

  // A stop that lands with a sample handshake is deferred one cycle so that sample's strobe still issues with rw=1.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    bank_d        = bank_q;
    strobe_d      = 1'b0;
    done_d        = 1'b0;
    stopPending_d = 1'b0;
    clipLen_d     = clipLen_q;
    unique case (state_q)
      IDLE: begin
        if (record_command_i) begin
          if (selValid) begin
            state_d = RECORD;
            bank_d  = clip_select_i;
            addr_d  = '0;
          end
        end else if (play_command_i && selValid && (selLen != '0)) begin
          state_d = PLAY;
          bank_d  = clip_select_i;
          addr_d  = '0;
        end
      end
      RECORD: begin
        if (stopPending_q || (strobe_q && (addr_q == LAST_ADDR)) ||
            (stop_command_i && !serializer_done_i)) begin
          state_d           = IDLE;
          done_d            = 1'b1;
          clipLen_d[bank_q] = recordedLen;
        end else begin
          strobe_d      = serializer_done_i;
          stopPending_d = stop_command_i;
          if (strobe_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      PLAY: begin
        if (stop_command_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (deserializer_done_i) begin
          if (LEN_WIDTH'(addr_q) == (bankLen - LEN_WIDTH'(1))) begin
            if (loop_enable_i) begin
              addr_d = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    serializer_enable_o   = (state_q == RECORD);
    deserializer_enable_o = (state_q == PLAY);
    memory_rw_o           = (state_q == RECORD);
    busy_o                = (state_q != IDLE);
    memory_addr_o         = addr_q;
    memory_bank_o         = bank_q;
    memory_strobe_o       = strobe_q;
    done_o                = done_q;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      clip_valid_o[i] = (clipLen_q[i] != '0);
    end
  end

endmodule

// File: tb/tb_clip_record_controller.sv
// Self-checking bench for clip_record_controller (8-sample clips); expectations come from
// a per-clip length table and sample-count arithmetic kept in the bench.
module tb_clip_record_controller;

  localparam int NUM_CLIPS  = 2;
  localparam int ADDR_WIDTH = 3;
  localparam int CLIP_DEPTH = 8;

  logic                  clock_i = 1'b0;
  logic                  reset_i = 1'b0;
  logic                  play_command_i = 1'b0;
  logic                  record_command_i = 1'b0;
  logic                  stop_command_i = 1'b0;
  logic                  loop_enable_i = 1'b0;
  logic [0:0]            clip_select_i = '0;
  logic                  serializer_done_i = 1'b0;
  logic                  deserializer_done_i = 1'b0;
  logic                  serializer_enable_o;
  logic                  deserializer_enable_o;
  logic [ADDR_WIDTH-1:0] memory_addr_o;
  logic                  memory_rw_o;
  logic                  memory_strobe_o;
  logic [0:0]            memory_bank_o;
  logic                  busy_o;
  logic                  done_o;
  logic [NUM_CLIPS-1:0]  clip_valid_o;

  int assertCount = 0;
  int failCount   = 0;
  int clipLen [NUM_CLIPS];

  clip_record_controller #(
    .NUM_CLIPS (NUM_CLIPS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CLIP_DEPTH(CLIP_DEPTH)
  ) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .play_command_i       (play_command_i),
    .record_command_i     (record_command_i),
    .stop_command_i       (stop_command_i),
    .loop_enable_i        (loop_enable_i),
    .clip_select_i        (clip_select_i),
    .serializer_done_i    (serializer_done_i),
    .deserializer_done_i  (deserializer_done_i),
    .serializer_enable_o  (serializer_enable_o),
    .deserializer_enable_o(deserializer_enable_o),
    .memory_addr_o        (memory_addr_o),
    .memory_rw_o          (memory_rw_o),
    .memory_strobe_o      (memory_strobe_o),
    .memory_bank_o        (memory_bank_o),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .clip_valid_o         (clip_valid_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clock_i);
    #1;
  endtask

  // Drive one cycle of inputs, let the edge capture them, then clear the pulses.
  task automatic applyStimulus(input logic rec, input logic play, input logic stop,
                               input logic ser, input logic des, input int sel);
    record_command_i    = rec;
    play_command_i      = play;
    stop_command_i      = stop;
    serializer_done_i   = ser;
    deserializer_done_i = des;
    clip_select_i       = 1'(sel);
    stepClock();
    record_command_i    = 1'b0;
    play_command_i      = 1'b0;
    stop_command_i      = 1'b0;
    serializer_done_i   = 1'b0;
    deserializer_done_i = 1'b0;
  endtask

  // Idle cycles while busy, sprinkled with commands that must be ignored.
  task automatic busyGap(input int maxGap);
    repeat ($urandom_range(0, maxGap))
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0,
                    $urandom_range(0, 1));
  endtask

  task automatic checkValid(input string tag);
    logic [NUM_CLIPS-1:0] expValid;
    for (int i = 0; i < NUM_CLIPS; i++) expValid[i] = (clipLen[i] != 0);
    checkOutput(tag, clip_valid_o, expValid);
  endtask

  task automatic doRecord(input int clip, input int nSamples, input int stopMode, input int maxGap);
    logic lastStop;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, clip);
    checkOutput("rec_start_flags",
                {busy_o, serializer_enable_o, deserializer_enable_o, memory_rw_o, memory_strobe_o, done_o},
                6'b110100);
    checkOutput("rec_start_addr", memory_addr_o, 0);
    checkOutput("rec_bank", memory_bank_o, clip);
    for (int j = 0; j < nSamples; j++) begin
      busyGap(maxGap);
      lastStop = (stopMode == 1) && (j == nSamples - 1);
      applyStimulus(1'b0, 1'b0, lastStop, 1'b1, 1'b0, clip);
      checkOutput("rec_strobe", {memory_strobe_o, memory_rw_o, busy_o}, 3'b111);
      checkOutput("rec_strobe_addr", memory_addr_o, j);
      stepClock();
      if ((j + 1 == CLIP_DEPTH) || lastStop) begin
        checkOutput("rec_end_flags",
                    {done_o, busy_o, serializer_enable_o, memory_rw_o, memory_strobe_o}, 5'b10000);
        checkOutput("rec_end_addr", memory_addr_o, j);
      end else begin
        checkOutput("rec_next_flags", {done_o, busy_o, memory_strobe_o}, 3'b010);
        checkOutput("rec_next_addr", memory_addr_o, j + 1);
      end
    end
    if (stopMode == 2) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, clip);
      checkOutput("rec_stop_flags", {done_o, busy_o, serializer_enable_o, memory_rw_o}, 4'b1000);
      checkOutput("rec_stop_addr", memory_addr_o, nSamples);
    end
    clipLen[clip] = nSamples;
    stepClock();
    checkOutput("rec_done_single", {done_o, busy_o}, 2'b00);
    checkValid("rec_clip_valid");
  endtask

  task automatic doPlay(input int clip, input int nPulses, input logic loopEn, input logic stopWithLast);
    int   len;
    int   expAddr;
    logic ended;
    logic stopNow;
    len = clipLen[clip];
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, clip);
    if (len == 0) begin
      checkOutput("play_empty_flags", {busy_o, deserializer_enable_o, done_o}, 3'b000);
      stepClock();
      checkOutput("play_empty_done", done_o, 1'b0);
      return;
    end
    checkOutput("play_start_flags",
                {busy_o, serializer_enable_o, deserializer_enable_o, memory_rw_o, memory_strobe_o, done_o},
                6'b101000);
    checkOutput("play_start_addr", memory_addr_o, 0);
    checkOutput("play_bank", memory_bank_o, clip);
    expAddr = 0;
    ended   = 1'b0;
    for (int p = 0; p < nPulses && !ended; p++) begin
      busyGap(2);
      stopNow = stopWithLast && (p == nPulses - 1);
      loop_enable_i = loopEn;
      applyStimulus(1'b0, 1'b0, stopNow, 1'b0, 1'b1, clip);
      if (stopNow || (expAddr == len - 1 && !loopEn)) begin
        ended = 1'b1;
        checkOutput("play_end_flags", {done_o, busy_o, deserializer_enable_o}, 3'b100);
        checkOutput("play_end_addr", memory_addr_o, expAddr);
      end else begin
        expAddr = (expAddr + 1) % len;
        checkOutput("play_step_flags", {done_o, busy_o, deserializer_enable_o}, 3'b011);
        checkOutput("play_step_addr", memory_addr_o, expAddr);
      end
    end
    if (!ended) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, clip);
      checkOutput("play_stop_flags", {done_o, busy_o, deserializer_enable_o}, 3'b100);
      checkOutput("play_stop_addr", memory_addr_o, expAddr);
    end
    loop_enable_i = 1'b0;
    stepClock();
    checkOutput("play_done_single", {done_o, busy_o}, 2'b00);
    checkValid("play_clip_valid");
  endtask

  initial begin
    int clip;
    int n;
    for (int i = 0; i < NUM_CLIPS; i++) clipLen[i] = 0;

    repeat (3) stepClock();
    checkOutput("reset_outputs",
                {busy_o, serializer_enable_o, deserializer_enable_o, memory_rw_o, memory_strobe_o,
                 done_o, memory_addr_o, memory_bank_o, clip_valid_o}, 0);
    reset_i = 1'b1;
    stepClock();
    checkOutput("post_reset_idle", {busy_o, done_o}, 2'b00);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("idle_stop_ignored", {busy_o, done_o}, 2'b00);

    $display("[TB] play on empty clip 0");
    doPlay(0, 3, 1'b0, 1'b0);

    $display("[TB] full record of clip 1");
    doRecord(1, CLIP_DEPTH, 0, 2);
    checkOutput("clip_valid_after_full", clip_valid_o, 2'b10);

    $display("[TB] play clip 1 once, then looped");
    doPlay(1, CLIP_DEPTH, 1'b0, 1'b0);
    doPlay(1, 20, 1'b1, 1'b0);

    $display("[TB] short record of clip 0 with stop on the last sample");
    doRecord(0, 4, 1, 1);
    doPlay(0, 4, 1'b0, 1'b0);
    doPlay(0, 4, 1'b0, 1'b1);

    $display("[TB] stop before any sample clears clip 0");
    doRecord(0, 0, 2, 0);
    doPlay(0, 2, 1'b0, 1'b0);

    $display("[TB] randomized operations");
    for (int it = 0; it < 12; it++) begin
      clip = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(0, CLIP_DEPTH);
        if (n == CLIP_DEPTH) doRecord(clip, n, 0, 2);
        else if (n > 0 && $urandom_range(0, 1) == 1) doRecord(clip, n, 1, 2);
        else doRecord(clip, n, 2, 2);
      end else begin
        doPlay(clip, $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] reset in the middle of a record");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      stepClock();
    end
    checkOutput("mid_record_addr", {busy_o, memory_addr_o}, {1'b1, 3'd5});
    #2;
    reset_i = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {busy_o, serializer_enable_o, deserializer_enable_o, memory_rw_o, memory_strobe_o,
                 done_o, memory_addr_o, memory_bank_o, clip_valid_o}, 0);
    for (int i = 0; i < NUM_CLIPS; i++) clipLen[i] = 0;
    repeat (2) stepClock();
    checkOutput("reset_no_done", done_o, 1'b0);
    reset_i = 1'b1;
    stepClock();
    checkOutput("after_reset_idle", {busy_o, done_o}, 2'b00);
    checkValid("after_reset_valid");
    doPlay(1, 2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/clip_record_controller.md
Name: clip_record_controller

Overview:
- Parametrised successor of the two-clip audio record/playback controller.
- Manages NUM_CLIPS clips, each stored in its own memory bank of up to CLIP_DEPTH samples.
- Counts addresses per sample handshake from the serializer (record) or deserializer (play), not from an external timer.
- Adds per-clip recorded length, a stop command, loop playback and a completion pulse. Sits between the synchronized user inputs and the memory banks / serializer / deserializer.

Parameters:
- NUM_CLIPS, 2, number of clips / memory banks (>=2).
- ADDR_WIDTH, 17, memory address width.
- CLIP_DEPTH, 131072, maximum samples per clip (1..2**ADDR_WIDTH).
- Derived: CLIP_BITS = max(1, $clog2(NUM_CLIPS)); LEN_WIDTH = ADDR_WIDTH+1.

Ports:
- clock_i  in  1  100 MHz clock
- reset_i  in  1  asynchronous, active-low reset
- play_command_i  in  1  play request, one-cycle pulse, synchronized
- record_command_i  in  1  record request, one-cycle pulse, synchronized
- stop_command_i  in  1  abort current operation, one-cycle pulse, synchronized
- loop_enable_i  in  1  level; playback wraps to address 0 at clip end when high
- clip_select_i  in  CLIP_BITS  clip to act on, sampled with the command
- serializer_done_i  in  1  one-cycle pulse: one input sample ready to write
- deserializer_done_i  in  1  one-cycle pulse: one output sample consumed
- serializer_enable_o  out  1  high while RECORD
- deserializer_enable_o  out  1  high while PLAY
- memory_addr_o  out  ADDR_WIDTH  current sample address
- memory_rw_o  out  1  1 = write (RECORD), 0 = read
- memory_strobe_o  out  1  one-cycle write strobe
- memory_bank_o  out  CLIP_BITS  active bank
- busy_o  out  1  high in PLAY or RECORD
- done_o  out  1  one-cycle pulse when an operation ends (natural end or stop)
- clip_valid_o  out  NUM_CLIPS  bit i set when clip i has length > 0

Behaviour:
- Reset (reset_i low, asynchronous): state IDLE; all outputs 0; all clip length registers 0. Applies mid-operation with no completion pulse; recorded data is lost logically.
- States: IDLE, PLAY, RECORD. All outputs are registered.
- IDLE arbitration, on a cycle with a command:
  - stop_command_i is ignored in IDLE.
  - Priority: record_command_i > play_command_i.
  - Record: at the next edge, enter RECORD; latch clip_select_i into memory_bank_o; set memory_addr_o = 0, memory_rw_o = 1, serializer_enable_o = 1, busy_o = 1.
  - Play: enter PLAY only if the selected clip length is nonzero (memory_rw_o = 0, deserializer_enable_o = 1, memory_addr_o = 0). Otherwise the command is ignored and no done_o pulse is issued.
  - clip_select_i values >= NUM_CLIPS are ignored.
- RECORD:
  - serializer_done_i high at cycle k -> memory_strobe_o high in cycle k+1 with memory_addr_o unchanged.
  - At the end of cycle k+1, the address increments.
  - Done pulses arrive at least 2 cycles apart. Play/record commands are ignored while busy.
  - Natural end: strobe at address CLIP_DEPTH-1 -> next edge to IDLE, length[bank] = CLIP_DEPTH, done_o pulses one cycle.
  - Stop: next edge to IDLE. length[bank] = number of strobes issued, including a strobe in the same cycle as stop. done_o pulses.
  - Stop before any sample gives length 0, which clears clip_valid for that clip.
  - The length register is written only at the end of RECORD.
- PLAY:
  - deserializer_done_i high -> next edge: address+1.
  - On a done pulse at address length-1: if loop_enable_i is high (sampled that cycle), address <- 0 and playback continues. Otherwise go to IDLE and pulse done_o.
  - Stop: next edge to IDLE, done_o pulses, length unchanged.
- Simultaneous events:
  - stop_command_i with serializer_done_i in RECORD: the sample is written (strobe still issued), then exit.
  - stop_command_i with a final deserializer_done_i in PLAY: exit once; done_o pulses exactly once.
- Upon leaving to IDLE: enables, memory_rw_o and busy_o drop to 0 at the same edge; memory_addr_o and memory_bank_o hold their last values.
- Arithmetic: the address counter never exceeds CLIP_DEPTH-1. Length registers are LEN_WIDTH bits wide so they can hold CLIP_DEPTH.

Test Plan:
- Reset, then play_command_i on clip 0 (length 0) -> remains IDLE, busy_o = 0, done_o never pulses.
- CLIP_DEPTH = 8: record clip 1 with 8 serializer_done_i pulses 4 cycles apart -> 8 strobes at addresses 0..7, memory_bank_o = 1, done_o pulses once, clip_valid_o = 2'b10, back in IDLE.
- Play clip 1, loop_enable_i = 0, 8 deserializer_done_i pulses -> memory_addr_o steps 0..7, done_o after the 8th pulse, deserializer_enable_o falls at the same edge.
- Play clip 1 with loop_enable_i = 1 for 20 pulses, then stop -> address sequence 0..7, 0..7, 0..3; single done_o on stop.
- Record clip 0: 3 samples, then stop in the same cycle as the 4th serializer_done_i -> 4 strobes, length 4; replay ends after 4 pulses.
- reset_i low mid-RECORD at address 5 -> all outputs 0 immediately (asynchronous), clip_valid_o = 0, no done_o pulse.
